// File: rtl/avalon_mem_rd_credit_limiter_if.sv
// Avalon-MM local-memory request/response bundle shared by the AFU side and the
// shim side of the read credit limiter.
interface avalon_mem_rd_credit_limiter_if #(
    parameter int ADDR_WIDTH  = 27,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [BURST_WIDTH-1:0]  burstcount;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_mem_rd_credit_limiter.sv
// Caps in-flight read beats toward the local-memory shim and blocks reads while a
// write burst is open. Optional statistics ports: AVALON_MEM_RD_LIMIT_STATS_EN.
module avalon_mem_rd_credit_limiter #(
    parameter int ADDR_WIDTH   = 27,
    parameter int DATA_WIDTH   = 512,
    parameter int BURST_WIDTH  = 7,
    parameter int MAX_RD_BEATS = 64
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    avalon_mem_rd_credit_limiter_if.slave         afu,
    avalon_mem_rd_credit_limiter_if.master        fiu,
    output logic [1:0]                            err_sticky
`ifdef AVALON_MEM_RD_LIMIT_STATS_EN
    ,
    output logic [31:0]                           stat_stall_cycles,
    output logic [$clog2(MAX_RD_BEATS+1)-1:0]     stat_peak_rd_out
`endif
);
    localparam int CW = $clog2(MAX_RD_BEATS + 1);
    localparam int SW = ((CW > BURST_WIDTH) ? CW : BURST_WIDTH) + 1;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WR_BURST = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [BURST_WIDTH-1:0] r_wr_left;
    logic [BURST_WIDTH-1:0] w_wr_left_next;
    logic [CW-1:0]          r_rd_out;
    logic [CW-1:0]          w_rd_out_next;
    logic [1:0]             r_err;
    logic [BURST_WIDTH-1:0] w_burst_eff;
    logic [SW-1:0]          w_rd_sum;
    logic                   w_bc_zero;
    logic                   w_rd_ok;
    logic                   w_rd_block;
    logic                   w_rd_accept;
    logic                   w_wr_accept;
    logic                   w_underflow;
    logic                   w_ret_ok;

    // A zero burstcount is flagged and then counted as a single beat.
    assign w_bc_zero   = (afu.burstcount == '0);
    assign w_burst_eff = w_bc_zero ? BURST_WIDTH'(1) : afu.burstcount;
    assign w_rd_sum    = SW'(r_rd_out) + SW'(w_burst_eff);
    assign w_rd_ok     = (w_rd_sum <= SW'(MAX_RD_BEATS)) && !w_rd_block;

    assign fiu.address       = afu.address;
    assign fiu.burstcount    = afu.burstcount;
    assign fiu.writedata     = afu.writedata;
    assign fiu.byteenable    = afu.byteenable;
    assign fiu.read          = afu.read & w_rd_ok;
    assign fiu.write         = afu.write;
    assign afu.waitrequest   = fiu.waitrequest | (afu.read & ~w_rd_ok);
    assign afu.readdata      = fiu.readdata;
    assign afu.readdatavalid = fiu.readdatavalid;

    assign w_rd_accept = afu.read & w_rd_ok & ~fiu.waitrequest;
    assign w_wr_accept = afu.write & ~fiu.waitrequest;
    assign w_underflow = fiu.readdatavalid && (r_rd_out == '0);
    assign w_ret_ok    = fiu.readdatavalid && !w_underflow;

    assign w_rd_out_next = r_rd_out
                         + (w_rd_accept ? CW'(w_burst_eff) : CW'(0))
                         - (w_ret_ok ? CW'(1) : CW'(0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_wr_left <= '0;
        end else begin
            r_state   <= w_state_next;
            r_wr_left <= w_wr_left_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_wr_left_next = r_wr_left;
        case (r_state)
            S_IDLE: begin
                if (w_wr_accept && (w_burst_eff > BURST_WIDTH'(1))) begin
                    w_state_next   = S_WR_BURST;
                    w_wr_left_next = w_burst_eff - BURST_WIDTH'(1);
                end
            end
            S_WR_BURST: begin
                if (w_wr_accept) begin
                    w_wr_left_next = r_wr_left - BURST_WIDTH'(1);
                    if (r_wr_left == BURST_WIDTH'(1)) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_block = 1'b0;
        if (r_state == S_WR_BURST) begin
            w_rd_block = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_out <= '0;
            r_err    <= '0;
        end else begin
            r_rd_out <= w_rd_out_next;
            if (w_underflow) begin
                r_err[0] <= 1'b1;
            end
            // Only the first beat of a write burst carries a meaningful burstcount.
            if (w_bc_zero && (w_rd_accept || (w_wr_accept && (r_state == S_IDLE)))) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    assign err_sticky = r_err;

`ifdef AVALON_MEM_RD_LIMIT_STATS_EN
    logic          w_stall;
    logic [31:0]   r_stall_cycles;
    logic [CW-1:0] r_peak_rd_out;

    assign w_stall = afu.read & ~w_rd_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_peak_rd_out  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (r_rd_out > r_peak_rd_out) begin
                r_peak_rd_out <= r_rd_out;
            end
        end
    end

    assign stat_stall_cycles = r_stall_cycles;
    assign stat_peak_rd_out  = r_peak_rd_out;
`else
    // Statistics disabled: no extra state or ports.
`endif

endmodule

// File: tb/tb_avalon_mem_rd_credit_limiter.sv
// Self-checking bench for avalon_mem_rd_credit_limiter: vector table plus
// hand-written multi-cycle sequences, with request/response scoreboards.
module tb_avalon_mem_rd_credit_limiter;
    localparam int AW  = 27;
    localparam int DW  = 512;
    localparam int BW  = 7;
    localparam int MAX = 64;
    localparam int CW  = $clog2(MAX + 1);

    logic clk;
    logic reset_n;
    logic [1:0] err_sticky;
`ifdef AVALON_MEM_RD_LIMIT_STATS_EN
    logic [31:0]   stat_stall_cycles;
    logic [CW-1:0] stat_peak_rd_out;
`endif

    avalon_mem_rd_credit_limiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) afu_if ();
    avalon_mem_rd_credit_limiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) fiu_if ();

    avalon_mem_rd_credit_limiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .MAX_RD_BEATS(MAX)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .afu               (afu_if),
        .fiu               (fiu_if),
        .err_sticky        (err_sticky)
`ifdef AVALON_MEM_RD_LIMIT_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_peak_rd_out  (stat_peak_rd_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
        logic [DW-1:0] wdata;
        logic [DW/8-1:0] be;
    } req_t;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [BW-1:0] bc;
        logic          fwait;
        logic          rdv;
        logic          e_awt;
        logic          e_frd;
        logic          e_fwr;
        int            e_rd;
    } vec_t;

    req_t          req_q[$];
    logic [DW-1:0] rd_q[$];
    req_t          mon_req;
    logic [DW-1:0] mon_data;
    vec_t          vecs[15];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_wide(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic idle_inputs();
        afu_if.read          = 1'b0;
        afu_if.write         = 1'b0;
        afu_if.burstcount    = '0;
        afu_if.address       = '0;
        afu_if.writedata     = '0;
        afu_if.byteenable    = '0;
        fiu_if.waitrequest   = 1'b0;
        fiu_if.readdatavalid = 1'b0;
        fiu_if.readdata      = '0;
    endtask

    // Drive one cycle, check the combinational outputs mid-cycle and rd_out after the edge.
    task automatic run_cycle(string name, logic rd, logic wr, logic [BW-1:0] bc, logic fwait,
                             logic rdv, logic e_awt, logic e_frd, logic e_fwr, int e_rd);
        req_t r;
        afu_if.read          = rd;
        afu_if.write         = wr;
        afu_if.burstcount    = bc;
        afu_if.address       = AW'($urandom);
        afu_if.writedata     = rand_data();
        afu_if.byteenable    = (DW/8)'({$urandom, $urandom});
        fiu_if.waitrequest   = fwait;
        fiu_if.readdatavalid = rdv;
        fiu_if.readdata      = rand_data();
        if (rdv) rd_q.push_back(fiu_if.readdata);
        if ((rd && e_frd && !fwait) || (wr && !fwait)) begin
            r.is_wr = wr;
            r.addr  = afu_if.address;
            r.bc    = bc;
            r.wdata = afu_if.writedata;
            r.be    = afu_if.byteenable;
            req_q.push_back(r);
        end
        @(negedge clk);
        check({name, "_afu_waitrequest"}, 64'(afu_if.waitrequest), 64'(e_awt));
        check({name, "_fiu_read"}, 64'(fiu_if.read), 64'(e_frd));
        check({name, "_fiu_write"}, 64'(fiu_if.write), 64'(e_fwr));
        @(posedge clk);
        #1;
        check({name, "_rd_out"}, 64'(dut.r_rd_out), 64'(e_rd));
        idle_inputs();
    endtask

    task automatic pulse_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted requests on the shim side and returned read beats on the AFU side.
    always @(negedge clk) begin
        if (reset_n) begin
            if ((fiu_if.read || fiu_if.write) && !fiu_if.waitrequest) begin
                check("req_expected", 64'(req_q.size() != 0), 64'd1);
                if (req_q.size() != 0) begin
                    mon_req = req_q.pop_front();
                    $display("req: %s addr=%0h bc=%0d", mon_req.is_wr ? "WR" : "RD",
                             fiu_if.address, fiu_if.burstcount);
                    check("req_kind", 64'(fiu_if.write), 64'(mon_req.is_wr));
                    check("req_addr", 64'(fiu_if.address), 64'(mon_req.addr));
                    check("req_bc", 64'(fiu_if.burstcount), 64'(mon_req.bc));
                    if (mon_req.is_wr) begin
                        check_wide("req_wdata", fiu_if.writedata, mon_req.wdata);
                        check("req_be", 64'(fiu_if.byteenable), 64'(mon_req.be));
                    end
                end
            end
            if (afu_if.readdatavalid) begin
                check("rdata_expected", 64'(rd_q.size() != 0), 64'd1);
                if (rd_q.size() != 0) begin
                    mon_data = rd_q.pop_front();
                    $display("rsp: data[31:0]=%0h", afu_if.readdata[31:0]);
                    check_wide("rdata", afu_if.readdata, mon_data);
                end
            end
        end
    end

    initial begin
        // rd, wr, bc, fwait, rdv | afu_wait, fiu_read, fiu_write, rd_out after edge
        vecs[0]  = '{1'b1, 1'b0, 7'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16};
        vecs[1]  = '{1'b1, 1'b0, 7'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32};
        vecs[2]  = '{1'b1, 1'b0, 7'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 48};
        vecs[3]  = '{1'b1, 1'b0, 7'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64};
        vecs[4]  = '{1'b1, 1'b0, 7'd16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64};
        vecs[5]  = '{1'b1, 1'b0, 7'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64};
        vecs[6]  = '{1'b0, 1'b1, 7'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64};
        vecs[7]  = '{1'b1, 1'b0, 7'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64};
        vecs[8]  = '{1'b0, 1'b0, 7'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 63};
        vecs[9]  = '{1'b1, 1'b0, 7'd1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 63};
        vecs[10] = '{1'b1, 1'b0, 7'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 63};
        vecs[11] = '{1'b1, 1'b0, 7'd1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 63};
        vecs[12] = '{1'b0, 1'b0, 7'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 62};
        vecs[13] = '{1'b1, 1'b0, 7'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64};
        vecs[14] = '{1'b0, 1'b1, 7'd1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64};

        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Combinational path follows inputs even while reset is held.
        afu_if.read       = 1'b1;
        afu_if.burstcount = 7'd8;
        @(negedge clk);
        check("rst_fiu_read_follows", 64'(fiu_if.read), 64'd1);
        @(posedge clk);
        #1;
        check("rst_rd_out", 64'(dut.r_rd_out), 64'd0);
        check("rst_err", 64'(err_sticky), 64'd0);
        idle_inputs();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Credit fill, stall at 64, writes independent of credits, netting accept+return.
        for (int i = 0; i < 15; i++) begin
            run_cycle($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].bc, vecs[i].fwait,
                      vecs[i].rdv, vecs[i].e_awt, vecs[i].e_frd, vecs[i].e_fwr, vecs[i].e_rd);
        end

        // Held burst-16 read waits out 16 returns, then issues the following cycle.
        for (int k = 0; k < 16; k++) begin
            run_cycle("t2_hold", 1'b1, 1'b0, 7'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 63 - k);
        end
        run_cycle("t2_issue", 1'b1, 1'b0, 7'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64);

        for (int k = 0; k < 64; k++) begin
            run_cycle("drain", 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 63 - k);
        end

        // Reads are blocked for the whole of a 4-beat write burst.
        run_cycle("t4_wr1", 1'b0, 1'b1, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_cycle("t4_rd_blk1", 1'b1, 1'b0, 7'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_cycle("t4_wr2", 1'b0, 1'b1, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_cycle("t4_wr3_wait", 1'b0, 1'b1, 7'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        run_cycle("t4_wr3", 1'b0, 1'b1, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_cycle("t4_rd_blk2", 1'b1, 1'b0, 7'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_cycle("t4_wr4", 1'b0, 1'b1, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_cycle("t4_rd_issue", 1'b1, 1'b0, 7'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        for (int k = 0; k < 4; k++) begin
            run_cycle("t4_ret", 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3 - k);
        end
        check("t4_err_clean", 64'(err_sticky), 64'd0);

        // Response underflow flags and holds rd_out at zero.
        pulse_reset();
        run_cycle("t5_underflow", 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("t5_err", 64'(err_sticky), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t5_err_sticky", 64'(err_sticky), 64'd1);

        // Zero burstcount counts as one beat and sets the second flag.
        run_cycle("zb_read", 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        check("zb_err", 64'(err_sticky), 64'd3);
        run_cycle("zb_ret", 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_cycle("zb_write", 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_cycle("zb_rd_after_wr", 1'b1, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        run_cycle("zb_ret2", 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        pulse_reset();
        check("rst_clears_err", 64'(err_sticky), 64'd0);

`ifdef AVALON_MEM_RD_LIMIT_STATS_EN
        check("stat_stall_rst", 64'(stat_stall_cycles), 64'd0);
        check("stat_peak_rst", 64'(stat_peak_rd_out), 64'd0);
        for (int k = 0; k < 4; k++) begin
            run_cycle("t6_fill", 1'b1, 1'b0, 7'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16 * (k + 1));
        end
        for (int k = 0; k < 10; k++) begin
            run_cycle("t6_stall", 1'b1, 1'b0, 7'd16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64);
        end
        @(posedge clk);
        #1;
        check("stat_stall_cycles", 64'(stat_stall_cycles), 64'd10);
        check("stat_peak_rd_out", 64'(stat_peak_rd_out), 64'd64);
        pulse_reset();
        check("stat_stall_cleared", 64'(stat_stall_cycles), 64'd0);
        check("stat_peak_cleared", 64'(stat_peak_rd_out), 64'd0);
`endif

        check("req_q_drained", 64'(req_q.size()), 64'd0);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
